eigen_deflation: RTL and testbench



---
 rtl/eigen_deflation_if.sv | 16 +
 rtl/eigen_deflation.sv | 200 ++++++++++++++++++++
 tb/tb_eigen_deflation.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/eigen_deflation_if.sv
// Handshake and data bundle for the eigen-deflation stage.
// The master side drives the operands, the slave side returns the deflated matrix.
interface eigen_deflation_if #(parameter int SIZE_N = 8);
    logic                                start;
    logic [SIZE_N-1:0][SIZE_N-1:0][63:0] timed_matrix;
    logic [SIZE_N-1:0][63:0]             vector;
    logic [63:0]                         eigenvalue;
    logic [SIZE_N-1:0][SIZE_N-1:0][63:0] deflated_matrix;
    logic                                busy;
    logic                                f;

    modport master (output start, timed_matrix, vector, eigenvalue,
                    input  deflated_matrix, busy, f);
    modport slave  (input  start, timed_matrix, vector, eigenvalue,
                    output deflated_matrix, busy, f);
endinterface

// File: rtl/eigen_deflation.sv
// Element-serial deflation B = A - lambda*v*v^T in IEEE-754 double precision.
// Subnormal operands and results are flushed to signed zero.
module eigen_deflation #(
    parameter int SIZE_N = 8
) (
    input  logic             clk,
    input  logic             rst,
    eigen_deflation_if.slave bus
);
    localparam int IW = (SIZE_N > 1) ? $clog2(SIZE_N) : 1;
    localparam logic [IW-1:0] LAST = IW'(SIZE_N - 1);
    localparam logic [63:0] QNAN = {1'b0, 11'h7ff, 52'h8000000000000};

    typedef enum logic [1:0] {IDLE = 2'd0, SCALE = 2'd1, DEFLATE = 2'd2, DONE = 2'd3} state_t;

    // Round-to-nearest-even on a 53-bit mantissa with guard/sticky, then pack.
    function automatic logic [63:0] fp_pack(input logic s, input logic signed [13:0] e_in,
                                            input logic [52:0] m, input logic g, input logic st);
        logic [53:0]        mr;
        logic signed [13:0] e;
        e  = e_in;
        mr = {1'b0, m} + ((g && (st || m[0])) ? 54'd1 : 54'd0);
        if (mr[53]) begin
            mr = mr >> 1;
            e  = e + 14'sd1;
        end else begin
            e  = e;
        end
        if (e >= 14'sd2047)   fp_pack = {s, 11'h7ff, 52'h0};
        else if (e <= 14'sd0) fp_pack = {s, 63'h0};
        else                  fp_pack = {s, e[10:0], mr[51:0]};
    endfunction

    function automatic logic [63:0] fp_mul(input logic [63:0] a, input logic [63:0] b);
        logic               s;
        logic [105:0]       prod;
        logic signed [13:0] e;
        s    = a[63] ^ b[63];
        prod = {53'h0, 1'b1, a[51:0]} * {53'h0, 1'b1, b[51:0]};
        e    = $signed({3'b000, a[62:52]}) + $signed({3'b000, b[62:52]}) - 14'sd1023;
        if (a[62:52] == 11'h7ff || b[62:52] == 11'h7ff) begin
            if ((a[62:52] == 11'h7ff && a[51:0] != 52'h0) || (b[62:52] == 11'h7ff && b[51:0] != 52'h0)
                || a[62:52] == 11'h0 || b[62:52] == 11'h0) fp_mul = QNAN;
            else fp_mul = {s, 11'h7ff, 52'h0};
        end else if (a[62:52] == 11'h0 || b[62:52] == 11'h0) begin
            fp_mul = {s, 63'h0};
        end else if (prod[105]) begin
            fp_mul = fp_pack(s, e + 14'sd1, prod[105:53], prod[52], |prod[51:0]);
        end else begin
            fp_mul = fp_pack(s, e, prod[104:52], prod[51], |prod[50:0]);
        end
    endfunction

    // Operands are ordered by magnitude so the aligned difference is never negative.
    function automatic logic [63:0] fp_add(input logic [63:0] a_in, input logic [63:0] b_in);
        logic [63:0]        a, b;
        logic [55:0]        ma, mb, r;
        logic [56:0]        sum;
        logic [10:0]        d;
        logic [5:0]         lz;
        logic signed [13:0] e;
        if (a_in[62:0] >= b_in[62:0]) begin a = a_in; b = b_in; end
        else                          begin a = b_in; b = a_in; end
        d  = a[62:52] - b[62:52];
        ma = {1'b1, a[51:0], 3'b000};
        mb = {1'b1, b[51:0], 3'b000};
        e  = $signed({3'b000, a[62:52]});
        lz = 6'd0;
        if (a[62:52] == 11'h7ff) begin
            if (a[51:0] != 52'h0 || (b[62:52] == 11'h7ff && a[63] != b[63])) fp_add = QNAN;
            else fp_add = a;
        end else if (b[62:52] == 11'h0) begin
            fp_add = (a[62:52] == 11'h0) ? {a[63] & b[63], 63'h0} : a;
        end else begin
            if (d > 11'd55) mb = 56'd1;
            else mb = (mb >> d) | {55'd0, |(mb & ((56'd1 << d) - 56'd1))};
            if (a[63] == b[63]) begin
                sum = {1'b0, ma} + {1'b0, mb};
                if (sum[56]) begin
                    r = sum[56:1] | {55'd0, sum[0]};
                    e = e + 14'sd1;
                end else begin
                    r = sum[55:0];
                end
                fp_add = fp_pack(a[63], e, r[55:3], r[2], |r[1:0]);
            end else begin
                r = ma - mb;
                if (r == 56'd0) begin
                    fp_add = 64'h0;
                end else begin
                    for (int k = 0; k < 56; k++) if (r[k]) lz = 6'(55 - k);
                    r = r << lz;
                    e = e - $signed({8'd0, lz});
                    fp_add = fp_pack(a[63], e, r[55:3], r[2], |r[1:0]);
                end
            end
        end
    endfunction

    state_t                              state_r;
    logic [SIZE_N-1:0][SIZE_N-1:0][63:0] a_r, dm_r;
    logic [SIZE_N-1:0][63:0]             v_r, p_r;
    logic [63:0]                         lambda_r;
    logic [IW-1:0]                       i_r, j_r;
    logic                                busy_r, f_r;
    logic [63:0]                         scale_s, prod_s, elem_s;

    // Shared arithmetic for the current SCALE index and DEFLATE element
    always_comb begin
        scale_s = fp_mul(lambda_r, v_r[i_r]);
        prod_s  = fp_mul(p_r[i_r], v_r[j_r]);
        elem_s  = fp_add(a_r[i_r][j_r], {~prod_s[63], prod_s[62:0]});
    end

    // Control FSM with latched operands, scaled vector and result matrix
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r  <= IDLE;
            a_r      <= '0;
            v_r      <= '0;
            p_r      <= '0;
            dm_r     <= '0;
            lambda_r <= 64'h0;
            i_r      <= '0;
            j_r      <= '0;
            busy_r   <= 1'b0;
            f_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    f_r <= 1'b0;
                    if (bus.start) begin
                        a_r      <= bus.timed_matrix;
                        v_r      <= bus.vector;
                        lambda_r <= bus.eigenvalue;
                        i_r      <= '0;
                        j_r      <= '0;
                        busy_r   <= 1'b1;
                        state_r  <= SCALE;
                    end else begin
                        busy_r   <= 1'b0;
                    end
                end
                SCALE: begin
                    if (!bus.start) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        p_r[i_r] <= scale_s;
                        if (i_r == LAST) begin
                            i_r     <= '0;
                            j_r     <= '0;
                            state_r <= DEFLATE;
                        end else begin
                            i_r     <= i_r + 1'b1;
                        end
                    end
                end
                DEFLATE: begin
                    if (!bus.start) begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        dm_r[i_r][j_r] <= elem_s;
                        if (j_r == LAST) begin
                            j_r <= '0;
                            if (i_r == LAST) begin
                                i_r     <= '0;
                                busy_r  <= 1'b0;
                                f_r     <= 1'b1;
                                state_r <= DONE;
                            end else begin
                                i_r     <= i_r + 1'b1;
                            end
                        end else begin
                            j_r <= j_r + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (!bus.start) begin
                        f_r     <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        f_r     <= 1'b1;
                    end
                end
                default: begin
                    busy_r  <= 1'b0;
                    f_r     <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus.deflated_matrix = dm_r;
    assign bus.busy            = busy_r;
    assign bus.f               = f_r;
endmodule

// File: tb/tb_eigen_deflation.sv
// Directed bench for eigen_deflation: a 2x2 vector table plus 8x8 abort/reset/latency sequences.
module tb_eigen_deflation;
    logic clk;
    logic rst;
    int   n_vec;
    int   n_fail;

    eigen_deflation_if #(.SIZE_N(2)) if2();
    eigen_deflation_if #(.SIZE_N(8)) if8();

    eigen_deflation #(.SIZE_N(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
    eigen_deflation #(.SIZE_N(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));

    typedef struct {
        real a00, a01, a10, a11;
        real v0, v1, lam;
        real b00, b01, b10, b11;
        int  tol;
    } vec2_t;

    vec2_t tab [6];
    real   a8 [8][8];
    real   e8 [8][8];
    real   v8 [8];
    real   lam8;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [63:0] ulp_diff(input logic [63:0] x, input logic [63:0] y);
        if (x[63] != y[63]) return {1'b0, x[62:0]} + {1'b0, y[62:0]};
        else if (x[62:0] > y[62:0]) return {1'b0, x[62:0] - y[62:0]};
        else return {1'b0, y[62:0] - x[62:0]};
    endfunction

    task automatic chk64(input string nm, input logic [63:0] act, input logic [63:0] exp, input int tol);
        n_vec++;
        if (ulp_diff(act, exp) > 64'(tol)) begin
            n_fail++;
            $display("FAIL %s: got %h (%g) want %h (%g)", nm, act, $bitstoreal(act), exp, $bitstoreal(exp));
        end
    endtask

    task automatic chk_int(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run2(input int idx, input vec2_t t);
        int edges;
        int busy_c;
        if2.timed_matrix[0][0] = $realtobits(t.a00);
        if2.timed_matrix[0][1] = $realtobits(t.a01);
        if2.timed_matrix[1][0] = $realtobits(t.a10);
        if2.timed_matrix[1][1] = $realtobits(t.a11);
        if2.vector[0]          = $realtobits(t.v0);
        if2.vector[1]          = $realtobits(t.v1);
        if2.eigenvalue         = $realtobits(t.lam);
        if2.start              = 1'b1;
        edges  = 0;
        busy_c = 0;
        while (!if2.f && edges < 40) begin
            step();
            edges++;
            if (if2.busy) busy_c++;
        end
        chk_int($sformatf("v%0d latency", idx), edges, 7);
        chk_int($sformatf("v%0d busy cycles", idx), busy_c, 6);
        chk64($sformatf("v%0d b00", idx), if2.deflated_matrix[0][0], $realtobits(t.b00), t.tol);
        chk64($sformatf("v%0d b01", idx), if2.deflated_matrix[0][1], $realtobits(t.b01), t.tol);
        chk64($sformatf("v%0d b10", idx), if2.deflated_matrix[1][0], $realtobits(t.b10), t.tol);
        chk64($sformatf("v%0d b11", idx), if2.deflated_matrix[1][1], $realtobits(t.b11), t.tol);
        if2.start = 1'b0;
        step();
        chk_int($sformatf("v%0d f clear", idx), int'(if2.f), 0);
    endtask

    task automatic drive8();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) if8.timed_matrix[i][j] = $realtobits(a8[i][j]);
            if8.vector[i] = $realtobits(v8[i]);
        end
        if8.eigenvalue = $realtobits(lam8);
    endtask

    task automatic run8(input string nm, input bit garbage);
        int edges;
        drive8();
        if8.start = 1'b1;
        edges = 0;
        while (!if8.f && edges < 200) begin
            step();
            edges++;
            if (garbage && edges == 1) begin
                for (int i = 0; i < 8; i++) begin
                    for (int j = 0; j < 8; j++) if8.timed_matrix[i][j] = {$urandom, $urandom};
                    if8.vector[i] = {$urandom, $urandom};
                end
                if8.eigenvalue = {$urandom, $urandom};
            end
        end
        chk_int({nm, " latency"}, edges, 73);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                chk64($sformatf("%s b[%0d][%0d]", nm, i, j), if8.deflated_matrix[i][j], $realtobits(e8[i][j]), 0);
    endtask

    function automatic int nonzero8();
        int c;
        c = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (if8.deflated_matrix[i][j] != 64'h0) c++;
        return c;
    endfunction

    task automatic model8();
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                e8[i][j] = a8[i][j] - (lam8 * v8[i]) * v8[j];
    endtask

    initial begin
        int fcount;
        n_vec  = 0;
        n_fail = 0;
        rst    = 1'b0;
        if2.start = 1'b0; if2.timed_matrix = '0; if2.vector = '0; if2.eigenvalue = 64'h0;
        if8.start = 1'b0; if8.timed_matrix = '0; if8.vector = '0; if8.eigenvalue = 64'h0;
        repeat (2) step();
        chk_int("reset busy", int'(if2.busy) + int'(if8.busy), 0);
        chk_int("reset f", int'(if2.f) + int'(if8.f), 0);
        chk_int("reset b8 zero", nonzero8(), 0);
        chk64("reset b2", if2.deflated_matrix[1][1], 64'h0, 0);
        rst = 1'b1;
        step();

        tab[0] = '{4.0, 1.0, 1.0, 3.0, 1.0, 0.0, 5.0, -1.0, 1.0, 1.0, 3.0, 0};
        tab[1] = '{2.0, 0.0, 0.0, 2.0, 0.70710678, 0.70710678, 2.0,
                   2.0 - (2.0 * 0.70710678) * 0.70710678, -((2.0 * 0.70710678) * 0.70710678),
                   -((2.0 * 0.70710678) * 0.70710678), 2.0 - (2.0 * 0.70710678) * 0.70710678, 4};
        tab[2] = '{1.5, -2.0, 0.25, 8.0, 0.5, 2.0, -3.0, 2.25, 1.0, 3.25, 20.0, 0};
        tab[3] = '{1.0, 1.0, 1.0, 1.0, 0.5, 0.5, 4.0, 0.0, 0.0, 0.0, 0.0, 0};
        tab[4] = '{1024.0, 3.0, 0.125, -7.0, 0.75, -0.5, 1.0, 1023.4375, 3.375, 0.5, -7.25, 0};
        tab[5] = '{1.0, 0.0, 0.0, 1.0, 1.0 / 3.0, 2.0 / 3.0, 1.0,
                   1.0 - (1.0 / 3.0) * (1.0 / 3.0), -((2.0 / 3.0) * (1.0 / 3.0)) * 1.0,
                   -((2.0 / 3.0) * (1.0 / 3.0)), 1.0 - (2.0 / 3.0) * (2.0 / 3.0), 0};
        for (int k = 0; k < 6; k++) run2(k, tab[k]);

        // Zero eigenvalue leaves A untouched; f held while start stays high
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) a8[i][j] = real'($urandom_range(0, 2000)) / 8.0 - 125.0;
            v8[i] = real'($urandom_range(1, 100)) / 16.0;
        end
        lam8 = 0.0;
        for (int i = 0; i < 8; i++) for (int j = 0; j < 8; j++) e8[i][j] = a8[i][j];
        run8("t3", 1'b0);
        repeat (3) step();
        chk_int("t3 f held", int'(if8.f), 1);
        chk_int("t3 busy low in done", int'(if8.busy), 0);
        if8.start = 1'b0;
        step();
        chk_int("t3 f clear", int'(if8.f), 0);

        // Asynchronous reset while element [3][5] is in flight
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) a8[i][j] = real'(i * 8 + j);
            v8[i] = 0.5;
        end
        lam8 = 2.0;
        model8();
        drive8();
        if8.start = 1'b1;
        repeat (38) step();
        chk_int("t4 busy before reset", int'(if8.busy), 1);
        #2 rst = 1'b0;
        #1;
        chk_int("t4 async busy", int'(if8.busy), 0);
        chk_int("t4 async f", int'(if8.f), 0);
        chk_int("t4 async b zero", nonzero8(), 0);
        step();
        rst = 1'b1;
        run8("t4", 1'b0);
        if8.start = 1'b0;
        step();

        // start dropped in SCALE aborts; previous result persists
        lam8 = 3.0;
        drive8();
        if8.start = 1'b1;
        repeat (4) step();
        chk_int("t5 busy in scale", int'(if8.busy), 1);
        if8.start = 1'b0;
        step();
        chk_int("t5 abort busy", int'(if8.busy), 0);
        fcount = 0;
        for (int c = 0; c < 80; c++) begin
            step();
            if (if8.f) fcount++;
        end
        chk_int("t5 f never", fcount, 0);
        chk64("t5 b kept", if8.deflated_matrix[0][0], $realtobits(-0.5), 0);
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) a8[i][j] = -real'(i * 8 + j);
            v8[i] = 0.25;
        end
        lam8 = 4.0;
        model8();
        run8("t5", 1'b0);
        if8.start = 1'b0;
        step();

        // Inputs scrambled after launch, then back-to-back with a one-cycle gap
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) a8[i][j] = real'(i - j);
            v8[i] = (i % 2 == 1) ? -1.0 : 1.0;
        end
        lam8 = 0.5;
        model8();
        run8("t6a", 1'b1);
        if8.start = 1'b0;
        step();
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) a8[i][j] = real'(i + 1) * 0.75;
            v8[i] = real'(i) * 0.125;
        end
        lam8 = -2.0;
        model8();
        run8("t6b", 1'b0);
        if8.start = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
